// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: resolves data-cache miss, taken branch,
// load-use and instruction-cache miss, and tracks miss wait time plus stall statistics.
module pipeline_hazard_ctrl #(
   parameter int MISS_TIMEOUT = 255,
   parameter int CNT_W        = 16
) (
   input  logic             inp_clk,
   input  logic             inp_rstn,
   input  logic             inp_icache_hit,
   input  logic             inp_mem_req,
   input  logic             inp_dcache_hit,
   input  logic             inp_branch_taken,
   input  logic             inp_idex_memRead,
   input  logic [2:0]       inp_idex_rt,
   input  logic [2:0]       inp_ifid_rs,
   input  logic [2:0]       inp_ifid_rt,
   input  logic             inp_ifid_uses_rt,
   output logic             out_pc_en,
   output logic             out_ifid_hit,
   output logic             out_idex_hit,
   output logic             out_exmem_hit,
   output logic             out_memwb_hit,
   output logic             out_ifid_flush,
   output logic             out_idex_flush,
   output logic [1:0]       out_state,
   output logic             out_timeout,
   output logic [CNT_W-1:0] out_stall_cnt
);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_IWAIT = 2'd1;
   localparam logic [1:0] ST_DWAIT = 2'd2;

   localparam int              WC_W     = $clog2(MISS_TIMEOUT + 1);
   localparam logic [WC_W-1:0] WC_MAX   = {WC_W{1'b1}};
   localparam logic [WC_W-1:0] WC_LIMIT = WC_W'(MISS_TIMEOUT - 1);
   localparam logic [WC_W-1:0] WC_ONE   = WC_W'(1);
   localparam logic [CNT_W-1:0] SC_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] SC_ONE  = CNT_W'(1);

   logic [1:0]       state;
   logic [1:0]       next_state;
   logic [WC_W-1:0]  wait_cnt;
   logic             timeout;
   logic [CNT_W-1:0] stall_cnt;
   logic             dmiss;
   logic             loaduse;
   logic             in_wait;

   // Hazard detection and the prioritised enable/flush decision
   always_comb begin
      dmiss   = inp_mem_req & ~inp_dcache_hit;
      loaduse = inp_idex_memRead & (inp_idex_rt != 3'd0) &
                ((inp_idex_rt == inp_ifid_rs) | (inp_ifid_uses_rt & (inp_idex_rt == inp_ifid_rt)));
      out_pc_en      = 1'b1;
      out_ifid_hit   = 1'b1;
      out_idex_hit   = 1'b1;
      out_exmem_hit  = 1'b1;
      out_memwb_hit  = 1'b1;
      out_ifid_flush = 1'b0;
      out_idex_flush = 1'b0;
      next_state     = ST_RUN;
      if (!inp_rstn) begin
         out_pc_en      = 1'b0;
         out_ifid_hit   = 1'b0;
         out_idex_hit   = 1'b0;
         out_exmem_hit  = 1'b0;
         out_memwb_hit  = 1'b0;
         out_ifid_flush = 1'b1;
         out_idex_flush = 1'b1;
         next_state     = ST_RUN;
      end else if ((state == ST_DWAIT) ? ~inp_dcache_hit : dmiss) begin
         // On the DWAIT exit cycle dmiss is ignored and the lower rows decide
         out_pc_en      = 1'b0;
         out_ifid_hit   = 1'b0;
         out_idex_hit   = 1'b0;
         out_exmem_hit  = 1'b0;
         out_memwb_hit  = 1'b0;
         next_state     = ST_DWAIT;
      end else if (inp_branch_taken) begin
         out_ifid_flush = 1'b1;
         out_idex_flush = 1'b1;
         next_state     = ST_RUN;
      end else if (loaduse) begin
         out_pc_en      = 1'b0;
         out_ifid_hit   = 1'b0;
         out_idex_flush = 1'b1;
         next_state     = inp_icache_hit ? ST_RUN : ST_IWAIT;
      end else if (!inp_icache_hit) begin
         out_pc_en      = 1'b0;
         out_ifid_flush = 1'b1;
         next_state     = ST_IWAIT;
      end else begin
         next_state     = ST_RUN;
      end
   end

   assign in_wait = (state == ST_IWAIT) || (state == ST_DWAIT);

   // State, wait counter, sticky timeout and saturating stall counter
   always_ff @(posedge inp_clk) begin
      if (!inp_rstn) begin
         state     <= ST_RUN;
         wait_cnt  <= {WC_W{1'b0}};
         timeout   <= 1'b0;
         stall_cnt <= {CNT_W{1'b0}};
      end else begin
         state <= next_state;
         if (in_wait && (next_state == state)) begin
            if (wait_cnt != WC_MAX) begin
               wait_cnt <= wait_cnt + WC_ONE;
            end
            if (wait_cnt == WC_LIMIT) begin
               timeout <= 1'b1;
            end
         end else begin
            wait_cnt <= {WC_W{1'b0}};
         end
         if (!out_pc_en && (stall_cnt != SC_MAX)) begin
            stall_cnt <= stall_cnt + SC_ONE;
         end
      end
   end

   assign out_state     = state;
   assign out_timeout   = timeout;
   assign out_stall_cnt = stall_cnt;

endmodule
